// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: buffers sim/mul/mem results in per-source FIFOs and
// drains them onto two registered PRF write ports with round-robin fairness.
module wb_write_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_PR     = 96,
    parameter int IDX_W      = 7,
    parameter int DATA_W     = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sim_valid,
    input  logic [IDX_W-1:0]  sim_pr_idx,
    input  logic [DATA_W-1:0] sim_value,
    output logic              sim_ready,
    input  logic              mul_valid,
    input  logic [IDX_W-1:0]  mul_pr_idx,
    input  logic [DATA_W-1:0] mul_value,
    output logic              mul_ready,
    input  logic              mem_valid,
    input  logic [IDX_W-1:0]  mem_pr_idx,
    input  logic [DATA_W-1:0] mem_value,
    output logic              mem_ready,
    output logic              wr_enable0,
    output logic [IDX_W-1:0]  wr_idx0,
    output logic [DATA_W-1:0] wr_value0,
    output logic              wr_enable1,
    output logic [IDX_W-1:0]  wr_idx1,
    output logic [DATA_W-1:0] wr_value1,
    output logic              idx_err,
    output logic              idle
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [2:0]              in_valid, in_ready, acc, legal, push, pop, nonempty;
    logic [2:0][IDX_W-1:0]   in_idx, head_idx;
    logic [2:0][DATA_W-1:0]  in_value, head_value;
    logic [2:0][CNT_W-1:0]   count_q;

    logic [1:0]              rr_ptr, rr_next, g0_src, g1_src, last_src, sel;
    logic [2:0]              scan_sum;
    logic                    g0_valid, g1_valid;

    assign in_valid = {mem_valid, mul_valid, sim_valid};
    assign in_idx   = {mem_pr_idx, mul_pr_idx, sim_pr_idx};
    assign in_value = {mem_value, mul_value, sim_value};

    assign sim_ready = in_ready[0];
    assign mul_ready = in_ready[1];
    assign mem_ready = in_ready[2];

    for (genvar s = 0; s < 3; s++) begin : g_src
        logic [IDX_W-1:0]  fifo_idx   [FIFO_DEPTH];
        logic [DATA_W-1:0] fifo_value [FIFO_DEPTH];
        logic [PTR_W-1:0]  head, tail;
        logic [CNT_W-1:0]  count;

        assign in_ready[s]   = count < CNT_W'(FIFO_DEPTH);
        assign acc[s]        = in_valid[s] && in_ready[s];
        assign legal[s]      = 32'(in_idx[s]) < NUM_PR;
        assign push[s]       = acc[s] && legal[s];
        assign nonempty[s]   = count != '0;
        assign count_q[s]    = count;
        assign head_idx[s]   = fifo_idx[head];
        assign head_value[s] = fifo_value[head];

        always_ff @(posedge clock) begin
            if (reset) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push[s]) begin
                    fifo_idx[tail]   <= in_idx[s];
                    fifo_value[tail] <= in_value[s];
                    tail             <= tail + 1'b1;
                end
                if (pop[s])
                    head <= head + 1'b1;
                case ({push[s], pop[s]})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Scan from rr_ptr; first non-empty source takes port 0, the next takes port 1.
    always_comb begin
        g0_valid = 1'b0;
        g1_valid = 1'b0;
        g0_src   = '0;
        g1_src   = '0;
        scan_sum = '0;
        sel      = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            scan_sum = {1'b0, rr_ptr} + 3'(k);
            sel      = (scan_sum >= 3'd3) ? 2'(scan_sum - 3'd3) : scan_sum[1:0];
            if (nonempty[sel]) begin
                if (!g0_valid) begin
                    g0_valid = 1'b1;
                    g0_src   = sel;
                end else if (!g1_valid) begin
                    g1_valid = 1'b1;
                    g1_src   = sel;
                end
            end
        end
        pop = '0;
        if (g0_valid) pop[g0_src] = 1'b1;
        if (g1_valid) pop[g1_src] = 1'b1;
        last_src = g1_valid ? g1_src : g0_src;
        if (!g0_valid)
            rr_next = rr_ptr;
        else
            rr_next = (last_src == 2'd2) ? 2'd0 : last_src + 2'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr     <= '0;
            wr_enable0 <= 1'b0;
            wr_idx0    <= '0;
            wr_value0  <= '0;
            wr_enable1 <= 1'b0;
            wr_idx1    <= '0;
            wr_value1  <= '0;
            idx_err    <= 1'b0;
        end else begin
            rr_ptr     <= rr_next;
            wr_enable0 <= g0_valid;
            wr_enable1 <= g1_valid;
            if (g0_valid) begin
                wr_idx0   <= head_idx[g0_src];
                wr_value0 <= head_value[g0_src];
            end
            if (g1_valid) begin
                wr_idx1   <= head_idx[g1_src];
                wr_value1 <= head_value[g1_src];
            end
            if (|(acc & ~legal))
                idx_err <= 1'b1;
        end
    end

    assign idle = (count_q == '0) && !wr_enable0 && !wr_enable1;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Randomized lockstep bench for wb_write_arbiter against a queue-based model
// of the buffering, round-robin grant and registered write ports.
module tb_wb_write_arbiter;
    localparam int DEPTH = 4;
    localparam int NPR   = 96;

    typedef struct {
        logic [6:0]  idx;
        logic [63:0] val;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        sim_valid, mul_valid, mem_valid;
    logic [6:0]  sim_pr_idx, mul_pr_idx, mem_pr_idx;
    logic [63:0] sim_value, mul_value, mem_value;
    logic        sim_ready, mul_ready, mem_ready;
    logic        wr_enable0, wr_enable1, idx_err, idle;
    logic [6:0]  wr_idx0, wr_idx1;
    logic [63:0] wr_value0, wr_value1;

    wb_write_arbiter #(.FIFO_DEPTH(DEPTH), .NUM_PR(NPR), .IDX_W(7), .DATA_W(64)) dut (
        .clock(clock), .reset(reset),
        .sim_valid(sim_valid), .sim_pr_idx(sim_pr_idx), .sim_value(sim_value), .sim_ready(sim_ready),
        .mul_valid(mul_valid), .mul_pr_idx(mul_pr_idx), .mul_value(mul_value), .mul_ready(mul_ready),
        .mem_valid(mem_valid), .mem_pr_idx(mem_pr_idx), .mem_value(mem_value), .mem_ready(mem_ready),
        .wr_enable0(wr_enable0), .wr_idx0(wr_idx0), .wr_value0(wr_value0),
        .wr_enable1(wr_enable1), .wr_idx1(wr_idx1), .wr_value1(wr_value1),
        .idx_err(idx_err), .idle(idle)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference state: buffered entries per source, round-robin start, expected outputs.
    ent_t        mq[3][$];
    ent_t        sq[3][$];
    ent_t        oe[3];
    bit          ov[3];
    int          rate[3];
    int          bad_pct;
    int          rr;
    bit          e_en0, e_en1, e_err;
    logic [6:0]  e_idx0, e_idx1;
    logic [63:0] e_val0, e_val1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        sim_valid  = ov[0]; sim_pr_idx = oe[0].idx; sim_value = oe[0].val;
        mul_valid  = ov[1]; mul_pr_idx = oe[1].idx; mul_value = oe[1].val;
        mem_valid  = ov[2]; mem_pr_idx = oe[2].idx; mem_value = oe[2].val;
    endtask

    // One clock: compare DUT to model, pick offers, advance model, wait to next negedge.
    task automatic step(input bit rst);
        bit   acc[3];
        int   ng, last, s;
        ent_t e;
        check_eq("wr_enable0", wr_enable0, e_en0);
        check_eq("wr_idx0", wr_idx0, e_idx0);
        check_eq("wr_value0", wr_value0, e_val0);
        check_eq("wr_enable1", wr_enable1, e_en1);
        check_eq("wr_idx1", wr_idx1, e_idx1);
        check_eq("wr_value1", wr_value1, e_val1);
        check_eq("idx_err", idx_err, e_err);
        check_eq("idle", idle, (mq[0].size() == 0 && mq[1].size() == 0 &&
                               mq[2].size() == 0 && !e_en0 && !e_en1));
        check_eq("sim_ready", sim_ready, mq[0].size() < DEPTH);
        check_eq("mul_ready", mul_ready, mq[1].size() < DEPTH);
        check_eq("mem_ready", mem_ready, mq[2].size() < DEPTH);

        for (int i = 0; i < 3; i++) begin
            if (!ov[i]) begin
                if (sq[i].size() > 0) begin
                    oe[i] = sq[i].pop_front();
                    ov[i] = 1'b1;
                end else if ($urandom_range(99) < rate[i]) begin
                    if ($urandom_range(99) < bad_pct)
                        oe[i].idx = 7'($urandom_range(127, NPR));
                    else
                        oe[i].idx = 7'($urandom_range(NPR - 1));
                    oe[i].val = {$urandom, $urandom};
                    ov[i]     = 1'b1;
                end
            end
        end
        drive();
        reset = rst;

        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                mq[i].delete();
                ov[i] = 1'b0;
            end
            rr = 0;
            e_en0 = 0; e_en1 = 0; e_err = 0;
            e_idx0 = '0; e_idx1 = '0; e_val0 = '0; e_val1 = '0;
        end else begin
            for (int i = 0; i < 3; i++)
                acc[i] = ov[i] && (mq[i].size() < DEPTH);
            ng = 0;
            last = 0;
            for (int k = 0; k < 3; k++) begin
                s = (rr + k) % 3;
                if (mq[s].size() > 0 && ng < 2) begin
                    e = mq[s].pop_front();
                    if (ng == 0) begin
                        e_en0 = 1; e_idx0 = e.idx; e_val0 = e.val;
                    end else begin
                        e_en1 = 1; e_idx1 = e.idx; e_val1 = e.val;
                    end
                    last = s;
                    ng++;
                end
            end
            if (ng < 1) e_en0 = 0;
            if (ng < 2) e_en1 = 0;
            if (ng > 0) rr = (last + 1) % 3;
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) begin
                    if (oe[i].idx < NPR) mq[i].push_back(oe[i]);
                    else e_err = 1;
                    ov[i] = 1'b0;
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic add(input int s, input int idx, input logic [63:0] val);
        ent_t e;
        e.idx = 7'(idx);
        e.val = val;
        sq[s].push_back(e);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            ov[i] = 0; rate[i] = 0; oe[i].idx = '0; oe[i].val = '0;
        end
        bad_pct = 0;
        rr = 0;
        e_en0 = 0; e_en1 = 0; e_err = 0;
        e_idx0 = '0; e_idx1 = '0; e_val0 = '0; e_val1 = '0;
        drive();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        check_eq("rst_en0", wr_enable0, 0);
        check_eq("rst_en1", wr_enable1, 0);
        check_eq("rst_idx0", wr_idx0, 0);
        check_eq("rst_val1", wr_value1, 0);
        check_eq("rst_err", idx_err, 0);
        check_eq("rst_idle", idle, 1);
        check_eq("rst_ready", {sim_ready, mul_ready, mem_ready}, 3'b111);

        // Single write latency: handshake edge, then write-port edge.
        add(0, 5, 64'hDEAD);
        step(1'b0);
        check_eq("lat_en0_early", wr_enable0, 0);
        step(1'b0);
        check_eq("lat_en0", wr_enable0, 1);
        check_eq("lat_idx0", wr_idx0, 5);
        check_eq("lat_val0", wr_value0, 64'hDEAD);
        check_eq("lat_en1", wr_enable1, 0);
        step(1'b0);
        check_eq("lat_idle", idle, 1);

        // All three sources streaming: round-robin rotation.
        for (int i = 0; i < 12; i++)
            for (int s = 0; s < 3; s++)
                add(s, s * 20 + i, {$urandom, $urandom});
        run(24);

        // Multiplier alone, six back-to-back results.
        for (int i = 0; i < 6; i++) add(1, 40 + i, 64'h1000 + 64'(i));
        run(12);

        // Illegal index is dropped and flags idx_err; legal index still written.
        add(2, 100, 64'hBAD);
        add(2, 7, 64'h7777);
        run(6);
        check_eq("err_sticky", idx_err, 1);

        // Reset with entries in flight.
        for (int i = 0; i < 3; i++) begin
            add(0, 10 + i, {$urandom, $urandom});
            add(2, 30 + i, {$urandom, $urandom});
        end
        run(3);
        step(1'b1);
        check_eq("mid_rst_en0", wr_enable0, 0);
        check_eq("mid_rst_en1", wr_enable1, 0);
        check_eq("mid_rst_idle", idle, 1);
        check_eq("mid_rst_err", idx_err, 0);
        check_eq("mid_rst_ready", {sim_ready, mul_ready, mem_ready}, 3'b111);
        add(0, 11, 64'h11);
        add(1, 22, 64'h22);
        run(2);
        check_eq("rr_restart_idx0", wr_idx0, 11);
        check_eq("rr_restart_idx1", wr_idx1, 22);

        // Randomized traffic with varying load, rare illegal indices and resets.
        bad_pct = 2;
        for (int blk = 0; blk < 8; blk++) begin
            for (int s = 0; s < 3; s++) rate[s] = int'($urandom_range(100, 20));
            for (int i = 0; i < 200; i++)
                step($urandom_range(199) == 0);
        end
        for (int s = 0; s < 3; s++) rate[s] = 0;
        run(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
